// File: rtl/cic_pkg.sv
// Shared CIC definitions: default sample width and the signed sample type
// used across the comb, upsampler and integrator blocks.
package cic_pkg;

  localparam int CIC_DATA_W = 32;
  localparam int CIC_MAX_STAGES = 8;

  typedef logic signed [CIC_DATA_W-1:0] cic_sample_t;

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: a registered accumulator, acc <= acc + in, wrapping
// modulo 2^DATA_W. The output is taken straight from the register.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int DATA_W = CIC_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in,
  output logic signed [DATA_W-1:0] out
);

  logic signed [DATA_W-1:0] acc_reg;

  // Carry-out is deliberately dropped: CIC growth cancels modulo 2^DATA_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_reg + in;
    end
  end

  assign out = acc_reg;

endmodule

// File: rtl/cic_integrator.sv
// Integrator section of a CIC interpolator: STAGES accumulators chained
// output-to-input, one sample per clock at the high rate.
module cic_integrator
  import cic_pkg::*;
#(
  parameter int DATA_W = CIC_DATA_W,
  parameter int STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] d_in,
  output logic signed [DATA_W-1:0] d_out
);

  // chain[k] is the input of stage k; chain[STAGES] is the last register.
  logic signed [DATA_W-1:0] chain [STAGES+1];

  assign chain[0] = d_in;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      cic_integrator_stage #(
        .DATA_W(DATA_W)
      ) u_stage (
        .clk(clk),
        .rst(rst),
        .in (chain[gi]),
        .out(chain[gi+1])
      );
    end
  endgenerate

  assign d_out = chain[STAGES];

endmodule

// File: tb/tb_cic_integrator.sv
// Self-checking bench for cic_integrator: a single-stage and a three-stage
// instance share clk, rst and d_in; expectations come from a vector table.
module tb_cic_integrator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] d_in = 32'sd0;
  logic signed [31:0] d_out1;
  logic signed [31:0] d_out3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cic_integrator #(.DATA_W(32), .STAGES(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .d_out(d_out1)
  );

  cic_integrator #(.DATA_W(32), .STAGES(3)) dut3 (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .d_out(d_out3)
  );

  typedef struct {
    logic               rst_first;
    logic signed [31:0] din;
    logic signed [31:0] exp1;
    logic               chk3;
    logic signed [31:0] exp3;
  } vec_t;

  typedef struct {
    logic signed [31:0] exp1;
    logic               chk3;
    logic signed [31:0] exp3;
  } exp_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one sample, let one edge pass, then compare against the queued expectation.
  task automatic step(input logic signed [31:0] din, input logic signed [31:0] exp1,
                      input logic chk3, input logic signed [31:0] exp3, input string name);
    exp_t e;
    d_in = din;
    e.exp1 = exp1;
    e.chk3 = chk3;
    e.exp3 = exp3;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " s1"}, d_out1, e.exp1);
      if (e.chk3) check({name, " s3"}, d_out3, e.exp3);
    end
  endtask

  // Assert reset between edges and confirm the outputs clear before any edge.
  task automatic apply_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, " async s1"}, d_out1, 32'h0);
    check({name, " async s3"}, d_out3, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Step from reset: both instances see d_in=1.
    vecs[0]  = '{1'b0, 32'sd1, 32'sd1, 1'b1, 32'sd0};
    vecs[1]  = '{1'b0, 32'sd1, 32'sd2, 1'b1, 32'sd0};
    vecs[2]  = '{1'b0, 32'sd1, 32'sd3, 1'b1, 32'sd1};
    vecs[3]  = '{1'b0, 32'sd1, 32'sd4, 1'b1, 32'sd4};
    vecs[4]  = '{1'b0, 32'sd1, 32'sd5, 1'b1, 32'sd10};
    vecs[5]  = '{1'b0, 32'sd1, 32'sd6, 1'b1, 32'sd20};
    // Impulse and hold, then negative input.
    vecs[6]  = '{1'b1, 32'sd5, 32'sd5, 1'b0, 32'sd0};
    vecs[7]  = '{1'b0, 32'sd0, 32'sd5, 1'b0, 32'sd0};
    vecs[8]  = '{1'b0, 32'sd0, 32'sd5, 1'b0, 32'sd0};
    vecs[9]  = '{1'b0, 32'sd0, 32'sd5, 1'b0, 32'sd0};
    vecs[10] = '{1'b0, -32'sd3, 32'sd2, 1'b0, 32'sd0};
    vecs[11] = '{1'b0, -32'sd3, -32'sd1, 1'b0, 32'sd0};
    // Two's-complement wrap at the positive limit.
    vecs[12] = '{1'b1, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 1'b0, 32'sd0};
    vecs[13] = '{1'b0, 32'sd1, 32'sh80000000, 1'b0, 32'sd0};
    vecs[14] = '{1'b0, -32'sd1, 32'sh7FFFFFFF, 1'b0, 32'sd0};

    // Held reset ignores d_in.
    rst = 1'b1;
    d_in = 32'sd123;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_rst[%0d] s1", i), d_out1, 32'h0);
      check($sformatf("hold_rst[%0d] s3", i), d_out3, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst_first) apply_reset($sformatf("vec[%0d] rst", i));
      step(vecs[i].din, vecs[i].exp1, vecs[i].chk3, vecs[i].exp3,
           $sformatf("vec[%0d] din=%0d", i, vecs[i].din));
    end

    // Mid-stream half-cycle reset pulse.
    apply_reset("mid rst");
    step(32'sd100, 32'sd100, 1'b0, 32'sd0, "mid acc");
    rst = 1'b1;
    d_in = 32'sd7;
    #1;
    check("mid pulse s1", d_out1, 32'h0);
    check("mid pulse s3", d_out3, 32'h0);
    #3;
    rst = 1'b0;
    step(32'sd7, 32'sd7, 1'b0, 32'sd0, "mid after1");
    step(32'sd7, 32'sd14, 1'b0, 32'sd0, "mid after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
